// File: rtl/dec_pkg.sv
// Shared command encodings for the one-hot step decoder and anything that drives it.
package dec_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_LOAD  = 2'b01,
        MODE_STEP  = 2'b10,
        MODE_PULSE = 2'b11
    } mode_e;

endpackage : dec_pkg

// File: rtl/dec_n_to_m.sv
// Combinational N-to-2^N one-hot decoder, no enable.
// Output is ascending [0:M-1]; index k asserts y[M-1-k], i.e. numeric weight 2^k.
module dec_n_to_m #(
    parameter  int N = 3,
    localparam int M = 2**N
) (
    input  logic [N-1:0] idx,
    output logic [0:M-1] y
);

    // Shifting a value left moves it toward y[0] in an ascending vector, which gives the k -> M-1-k mapping.
    always_comb begin
        y = {{(M-1){1'b0}}, 1'b1} << idx;
    end

endmodule : dec_n_to_m

// File: rtl/dec_onehot_seq.sv
// Registered one-hot decoder with load/hold/step/pulse commands; 1-cycle latency from command to outputs.
// Reset beats En, En beats the command; a pulse is cleared by a following HOLD.
module dec_onehot_seq
    import dec_pkg::*;
#(
    parameter  int N = 3,
    localparam int M = 2**N
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic [N-1:0] W,
    input  logic         En,
    input  logic [1:0]   Mode,
    output logic [0:M-1] Y,
    output logic [N-1:0] K,
    output logic         Active,
    output logic         Wrap
);

    logic [0:M-1] y_q, y_d;
    logic [N-1:0] k_q, k_d;
    logic         active_q, active_d;
    logic         wrap_q, wrap_d;
    logic         pend_q, pend_d;
    logic [0:M-1] dec_y;

    // Y is always onehot(K) while active, so it is rebuilt from the next index rather than stored separately.
    always_comb begin
        k_d      = k_q;
        active_d = active_q;
        wrap_d   = 1'b0;
        pend_d   = 1'b0;
        if (!En) begin
            active_d = 1'b0;
        end else begin
            case (mode_e'(Mode))
                MODE_HOLD: begin
                    if (pend_q) begin
                        active_d = 1'b0;
                    end
                end
                MODE_LOAD: begin
                    k_d      = W;
                    active_d = 1'b1;
                end
                MODE_STEP: begin
                    if (active_q) begin
                        k_d    = k_q + 1'b1;
                        wrap_d = (k_q == '1);
                    end else begin
                        k_d    = '0;
                    end
                    active_d = 1'b1;
                end
                MODE_PULSE: begin
                    k_d      = W;
                    active_d = 1'b1;
                    pend_d   = 1'b1;
                end
            endcase
        end
    end

    dec_n_to_m #(.N(N)) u_dec (
        .idx (k_d),
        .y   (dec_y)
    );

    assign y_d = active_d ? dec_y : '0;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            y_q      <= '0;
            k_q      <= '0;
            active_q <= 1'b0;
            wrap_q   <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            y_q      <= y_d;
            k_q      <= k_d;
            active_q <= active_d;
            wrap_q   <= wrap_d;
            pend_q   <= pend_d;
        end
    end

    assign Y      = y_q;
    assign K      = k_q;
    assign Active = active_q;
    assign Wrap   = wrap_q;

endmodule : dec_onehot_seq

// File: tb/tb_dec_onehot_seq.sv
// Directed-vector bench for dec_onehot_seq at N=3, with N=4 and N=1 instances for parametric corners.
module tb_dec_onehot_seq;
    import dec_pkg::*;

    logic        clk;
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [2:0]  w;
    logic [0:7]  y8;
    logic [2:0]  k8;
    logic        act8;
    logic        wrap8;

    logic [1:0]  mode4;
    logic [3:0]  w4;
    logic [0:15] y16;
    logic [3:0]  k4;
    logic        act4;
    logic        wrap4;

    logic [1:0]  mode1;
    logic [0:0]  w1;
    logic [0:1]  y2;
    logic [0:0]  k1;
    logic        act1;
    logic        wrap1;

    int n_vec = 0;
    int n_err = 0;
    int n_wraps;

    dec_onehot_seq #(.N(3)) u_dut (
        .Clock(clk), .Reset(rst), .W(w), .En(en), .Mode(mode),
        .Y(y8), .K(k8), .Active(act8), .Wrap(wrap8)
    );

    dec_onehot_seq #(.N(4)) u_dut4 (
        .Clock(clk), .Reset(rst), .W(w4), .En(en), .Mode(mode4),
        .Y(y16), .K(k4), .Active(act4), .Wrap(wrap4)
    );

    dec_onehot_seq #(.N(1)) u_dut1 (
        .Clock(clk), .Reset(rst), .W(w1), .En(en), .Mode(mode1),
        .Y(y2), .K(k1), .Active(act1), .Wrap(wrap1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_st(input string tag, input logic [31:0] ey, input logic [31:0] ek,
                          input logic [31:0] ea, input logic [31:0] ew);
        chk({tag, "_y"}, 32'(y8), ey);
        chk({tag, "_k"}, 32'(k8), ek);
        chk({tag, "_act"}, 32'(act8), ea);
        chk({tag, "_wrap"}, 32'(wrap8), ew);
    endtask

    task automatic tick(input logic r, input logic e, input logic [1:0] m, input logic [2:0] wi);
        rst  = r;
        en   = e;
        mode = m;
        w    = wi;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 0; rst = 1; en = 1; mode = MODE_HOLD; w = '0;
        mode4 = MODE_HOLD; w4 = '0; mode1 = MODE_HOLD; w1 = '0;

        // Reset must win over a simultaneous LOAD
        tick(1, 1, MODE_HOLD, 3'd0);
        tick(1, 1, MODE_LOAD, 3'd7);
        chk_st("reset", 32'h00, 0, 0, 0);
        chk("reset_y16", 32'(y16), 32'h0);
        chk("reset_y2", 32'(y2), 32'h0);

        tick(0, 1, MODE_LOAD, 3'd5);
        chk_st("load5", 32'h20, 5, 1, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, MODE_HOLD, 3'(i));
            chk_st($sformatf("hold%0d", i), 32'h20, 5, 1, 0);
        end

        tick(0, 1, MODE_LOAD, 3'd6);
        chk_st("load6", 32'h40, 6, 1, 0);
        tick(0, 1, MODE_STEP, 3'd2);
        chk_st("step7", 32'h80, 7, 1, 0);
        tick(0, 1, MODE_STEP, 3'd2);
        chk_st("step_wrap", 32'h01, 0, 1, 1);
        tick(0, 1, MODE_HOLD, 3'd0);
        chk_st("wrap_clear", 32'h01, 0, 1, 0);

        tick(1, 1, MODE_HOLD, 3'd0);
        tick(0, 1, MODE_STEP, 3'd5);
        chk_st("step_idle", 32'h01, 0, 1, 0);
        n_wraps = 0;
        for (int i = 0; i < 8; i++) begin
            tick(0, 1, MODE_STEP, 3'(i));
            if (wrap8) n_wraps++;
            chk($sformatf("step8_k%0d", i), 32'(k8), (i + 1) % 8);
            chk($sformatf("step8_y%0d", i), 32'(y8), 32'(1) << ((i + 1) % 8));
        end
        chk("step8_wraps", n_wraps, 1);

        tick(0, 1, MODE_PULSE, 3'd2);
        chk_st("pulse2", 32'h04, 2, 1, 0);
        tick(0, 1, MODE_HOLD, 3'd0);
        chk_st("pulse2_end", 32'h00, 2, 0, 0);
        tick(0, 1, MODE_HOLD, 3'd0);
        chk_st("pulse2_idle", 32'h00, 2, 0, 0);
        tick(0, 1, MODE_PULSE, 3'd1);
        chk_st("pulse1", 32'h02, 1, 1, 0);
        tick(0, 1, MODE_PULSE, 3'd3);
        chk_st("pulse3", 32'h08, 3, 1, 0);
        tick(0, 1, MODE_HOLD, 3'd0);
        chk_st("pulse3_end", 32'h00, 3, 0, 0);
        // A LOAD after a pulse replaces it and persists through HOLD
        tick(0, 1, MODE_PULSE, 3'd4);
        tick(0, 1, MODE_LOAD, 3'd1);
        tick(0, 1, MODE_HOLD, 3'd0);
        chk_st("pulse_then_load", 32'h02, 1, 1, 0);

        tick(0, 1, MODE_LOAD, 3'd3);
        tick(0, 0, MODE_LOAD, 3'd4);
        chk_st("en_off_load", 32'h00, 3, 0, 0);
        tick(0, 1, MODE_HOLD, 3'd4);
        chk_st("en_off_hold", 32'h00, 3, 0, 0);
        tick(0, 1, MODE_LOAD, 3'd2);
        tick(0, 0, MODE_HOLD, 3'd0);
        chk_st("en_off_active", 32'h00, 2, 0, 0);

        tick(0, 1, MODE_LOAD, 3'd5);
        tick(0, 1, MODE_STEP, 3'd0);
        chk_st("pre_rst_step", 32'h40, 6, 1, 0);
        tick(1, 1, MODE_STEP, 3'd0);
        chk_st("rst_mid_step", 32'h00, 0, 0, 0);

        mode4 = MODE_LOAD; w4 = 4'd15;
        mode1 = MODE_LOAD; w1 = 1'b1;
        tick(0, 1, MODE_HOLD, 3'd0);
        chk("n4_load15_y", 32'(y16), 32'h8000);
        chk("n4_load15_k", 32'(k4), 15);
        chk("n1_load1_y", 32'(y2), 32'h2);
        chk("n1_load1_k", 32'(k1), 1);
        mode4 = MODE_STEP;
        mode1 = MODE_STEP;
        tick(0, 1, MODE_HOLD, 3'd0);
        chk("n4_wrap_y", 32'(y16), 32'h0001);
        chk("n4_wrap_k", 32'(k4), 0);
        chk("n4_wrap_flag", 32'(wrap4), 1);
        chk("n1_wrap_y", 32'(y2), 32'h1);
        chk("n1_wrap_flag", 32'(wrap1), 1);
        chk("n4_active", 32'(act4), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_dec_onehot_seq
